// File: rtl/dlx_mem_access_unit_pkg.sv
// Shared types for the DLX MEM-stage load/store engine:
// access-size codes and the controller state encoding.
package dlx_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int MEM_WORDS_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_WR,
        S_RSP
    } state_e;

endpackage

// File: rtl/dlx_mem_access_unit_if.sv
// Request/response handshake plus the word-wide RAM port.
// slave = the access unit, master = pipeline and RAM side.
interface dlx_mem_access_unit_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_adr_o;
    logic        mem_we_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i,
        input  req_signed_i, req_addr_i, req_wdata_i,
        input  mem_data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output rsp_err_o, mem_adr_o, mem_we_o, mem_data_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i,
        output req_signed_i, req_addr_i, req_wdata_i,
        output mem_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  rsp_err_o, mem_adr_o, mem_we_o, mem_data_o
    );

endinterface

// File: rtl/dlx_mem_access_unit_lane.sv
// Big-endian byte-lane logic: extract/extend load data and
// merge sub-word store data into the word read from RAM.
module dlx_lane_merge
    import dlx_mem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sgn_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_o,
    output logic [31:0] st_o
);

    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;

    always_comb begin
        // offset 0 is the most significant lane
        sh_b = {~off_i, 3'b000};
        sh_h = {~off_i[1], 4'b0000};
        b    = 8'(word_i >> sh_b);
        h    = 16'(word_i >> sh_h);
        mask = '0;
        ld_o = word_i;
        st_o = wdata_i;
        unique case (size_i)
            SIZE_BYTE: begin
                ld_o = {{24{sgn_i & b[7]}}, b};
                mask = 32'h0000_00ff << sh_b;
                st_o = (word_i & ~mask)
                     | ({24'd0, wdata_i[7:0]} << sh_b);
            end
            SIZE_HALF: begin
                ld_o = {{16{sgn_i & h[15]}}, h};
                mask = 32'h0000_ffff << sh_h;
                st_o = (word_i & ~mask)
                     | ({16'd0, wdata_i[15:0]} << sh_h);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dlx_mem_access_unit.sv
// MEM-stage load/store engine driving a word-wide synchronous
// RAM; sub-word stores are done as read-modify-write.
module dlx_mem_access_unit
    import dlx_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input logic clk_i,
    input logic reset,
    dlx_mem_access_unit_if.slave bus
);

    state_e      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] mdat_q, mdat_d;

    logic [29:0] widx;
    logic        oor;
    logic        bad;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    dlx_lane_merge u_lane (
        .off_i   (off_q),
        .size_i  (size_q),
        .sgn_i   (sgn_q),
        .word_i  (bus.mem_data_i),
        .wdata_i (wdata_q),
        .ld_o    (ld_data),
        .st_o    (st_word)
    );

    always_comb begin
        widx = bus.req_addr_i[31:2];
        oor  = (|widx[29:IDX_W])
             | ({1'b0, widx[IDX_W-1:0]}
                >= (IDX_W+1)'(MEM_WORDS));
        bad  = oor
             | (bus.req_size_i == 2'b11)
             | ((bus.req_size_i == SIZE_HALF)
                & bus.req_addr_i[0])
             | ((bus.req_size_i == SIZE_WORD)
                & (|bus.req_addr_i[1:0]));
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        adr_d   = adr_q;
        mdat_d  = mdat_q;
        unique case (state_q)
            S_IDLE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                if (bus.req_valid_i) begin
                    off_d   = bus.req_addr_i[1:0];
                    size_d  = bus.req_size_i;
                    sgn_d   = bus.req_signed_i;
                    we_d    = bus.req_we_i;
                    wdata_d = bus.req_wdata_i;
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else begin
                        adr_d = {2'b00, widx};
                        if (bus.req_we_i
                            && bus.req_size_i == SIZE_WORD) begin
                            mdat_d  = bus.req_wdata_i;
                            state_d = S_WR;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD:  state_d = S_RDW;
            S_RDW: begin
                if (we_q) begin
                    mdat_d  = st_word;
                    state_d = S_WR;
                end else begin
                    rdata_d = ld_data;
                    state_d = S_RSP;
                end
            end
            S_WR:  state_d = S_RSP;
            S_RSP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            adr_q   <= '0;
            mdat_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
            mdat_q  <= mdat_d;
        end
    end

    // reset gates the write strobe so an interrupted WR never lands
    assign bus.mem_we_o    = (state_q == S_WR) & ~reset;
    assign bus.mem_adr_o   = adr_q;
    assign bus.mem_data_o  = mdat_q;
    assign bus.req_ready_o = (state_q == S_IDLE);
    assign bus.rsp_valid_o = (state_q == S_RSP);
    assign bus.rsp_rdata_o = bus.rsp_valid_o ? rdata_q : '0;
    assign bus.rsp_err_o   = bus.rsp_valid_o & err_q;

endmodule

// File: tb/tb_dlx_mem_access_unit.sv
// Randomized scoreboard bench for dlx_mem_access_unit against a
// byte-array reference memory.
module tb_dlx_mem_access_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dlx_mem_access_unit_if bus ();

    dlx_mem_access_unit dut (
        .clk_i (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model with a backdoor port for preloading
    logic [31:0] ram [64];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;

    always @(posedge clk) begin
        if (bd_we) ram[bd_idx] <= bd_val;
        else if (bus.mem_we_o) ram[bus.mem_adr_o[5:0]] <= bus.mem_data_o;
        bus.mem_data_i <= ram[bus.mem_adr_o[5:0]];
    end

    // reference memory as big-endian bytes
    logic [7:0] ref_b [256];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
        int          acc;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [1:0] sz,
                                   input logic sgn, input logic [31:0] addr,
                                   input logic [31:0] wd);
        exp_t e;
        int   nb;
        int   a;
        logic [31:0] v;
        nb = 1 << sz;
        e.rdata = 0;
        e.wes = 0;
        e.acc = 0;
        e.err = (sz == 2'd3) || (sz == 2'd1 && addr[0])
             || (sz == 2'd2 && addr[1:0] != 0) || (addr / 4 >= 64);
        if (e.err) begin
            e.lat = 1;
        end else if (we) begin
            a = int'(addr);
            for (int i = 0; i < nb; i++)
                ref_b[a+i] = 8'(wd >> (8 * (nb - 1 - i)));
            e.lat = (sz == 2'd2) ? 2 : 4;
            e.wes = 1;
        end else begin
            a = int'(addr);
            v = 0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_b[a+i]);
            if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hffff_ffff << (8 * nb));
            e.rdata = v;
            e.lat = 3;
        end
        return e;
    endfunction

    function automatic logic [31:0] ref_word(input int i);
        return {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]};
    endfunction

    // monitor: pops expectations whenever a response appears
    int we_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            we_cnt = 0;
        end else begin
            if (bus.mem_we_o) we_cnt++;
            if (bus.rsp_valid_o) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                    check("rsp_err", 32'(bus.rsp_err_o), 32'(e.err));
                    check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                    check("we_pulses", 32'(we_cnt), 32'(e.wes));
                end
                we_cnt = 0;
            end
        end
    end

    task automatic set_word(input int i, input logic [31:0] v);
        bd_idx = 6'(i);
        bd_val = v;
        bd_we = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
        for (int k = 0; k < 4; k++) ref_b[4*i+k] = 8'(v >> (8 * (3 - k)));
    endtask

    // returns at #1 after the accepting edge with valid still high
    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wd, input bit track);
        int w;
        exp_t e;
        bus.req_valid_i = 1'b1;
        bus.req_we_i = we;
        bus.req_size_i = sz;
        bus.req_signed_i = sgn;
        bus.req_addr_i = addr;
        bus.req_wdata_i = wd;
        w = 0;
        while (!bus.req_ready_o && w < 20) begin
            @(posedge clk);
            #1 w++;
        end
        if (!bus.req_ready_o) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.req_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (track) begin
                e = model(we, sz, sgn, addr, wd);
                e.acc = cyc - 1;
                sbq.push_back(e);
            end
            check("ready_busy", 32'(bus.req_ready_o), 32'd0);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 100) begin
            @(posedge clk);
            #1 w++;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        bus.req_valid_i = 1'b0;
        bus.req_we_i = 1'b0;
        bus.req_size_i = '0;
        bus.req_signed_i = 1'b0;
        bus.req_addr_i = '0;
        bus.req_wdata_i = '0;
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_we", 32'(bus.mem_we_o), 32'd0);
        check("rst_adr", bus.mem_adr_o, 32'd0);
        check("rst_data", bus.mem_data_o, 32'd0);
        check("rst_rdata", bus.rsp_rdata_o, 32'd0);
        check("rst_err", 32'(bus.rsp_err_o), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        set_word(3, 32'h1122_3344);
        issue(1'b0, 2'd0, 1'b1, 32'h0d, 0, 1'b1);
        bus.req_valid_i = 1'b0;
        drain();
        set_word(3, 32'h80ff_7f01);
        issue(1'b0, 2'd1, 1'b1, 32'h0c, 0, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h0e, 0, 1'b1);
        bus.req_valid_i = 1'b0;
        drain();
        set_word(2, 32'haabb_ccdd);
        issue(1'b1, 2'd0, 1'b0, 32'h0a, 32'h55, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h08, 0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h06, 32'h1, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 0, 1'b1);
        bus.req_valid_i = 1'b0;
        drain();
        check("ram2_rmw", ram[2], 32'haabb_55dd);

        // reset lands while the word store sits in WR
        issue(1'b1, 2'd2, 1'b0, 32'h08, 32'h1234_5678, 1'b0);
        bus.req_valid_i = 1'b0;
        check("wr_we_high", 32'(bus.mem_we_o), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_mid_ready", 32'(bus.req_ready_o), 32'd1);
        repeat (4) @(posedge clk);
        #1 check("rst_mid_ram2", ram[2], ref_word(2));

        // back-to-back store then load with valid held
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hdead_beef, 1'b1);
        issue(1'b0, 2'd2, 1'b1, 32'h20, 0, 1'b1);
        bus.req_valid_i = 1'b0;
        drain();

        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                bus.req_valid_i = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        bus.req_valid_i = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) check("ram_final", ram[i], ref_word(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
